sdram_port_responder: RTL
=========================

SDRAM_PORT_RESPONDER -- requirements
Module: sdram_port_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 256, maximum cycles waited for read data.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-low.
REQ-006 client_read  in  1  read request; held high until client_finished.
REQ-007 client_write  in  1  write request; held high until client_finished.
REQ-008 client_addr  in  ADDR_W  word address.
REQ-009 client_writedata  in  DATA_W  write data.
REQ-010 client_readdata  out  DATA_W  read result; valid while client_finished=1, held afterwards.
REQ-011 client_finished  out  1  one-cycle completion pulse.
REQ-012 client_err  out  1  sticky error flag (timeout or read+write both high).
REQ-013 avm_address  out  ADDR_W  SDRAM controller address.
REQ-014 avm_read / avm_write  out  1 each  SDRAM controller commands.
REQ-015 avm_writedata  out  DATA_W  write data; avm_byteenable  out  4  fixed 4'hF.
REQ-016 avm_waitrequest  in  1  controller stall; avm_readdata  in  DATA_W; avm_readdatavalid  in  1.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT_RD, DONE.
REQ-018 IDLE: if client_read or client_write is 1, latch addr, writedata and op into registers, go to REQ; otherwise stay.
REQ-019 read and write both 1 in IDLE SHALL be treated as read and SHALL set client_err.
REQ-020 REQ: avm_read or avm_write = 1, driven from latched registers only; address/data stable while avm_waitrequest=1.
REQ-021 REQ with avm_waitrequest=0: write -> DONE; read -> WAIT_RD, or directly to DONE with data latched if avm_readdatavalid=1 that same cycle.
REQ-022 WAIT_RD: on avm_readdatavalid=1, latch avm_readdata into client_readdata and go to DONE.
REQ-023 WAIT_RD: a counter cleared on entry SHALL reach TIMEOUT_CYC-1 without readdatavalid -> client_readdata = 32'hDEADBEEF, set client_err, go to DONE.
REQ-024 DONE: client_finished = 1 for exactly one cycle, then IDLE unconditionally.
REQ-025 Requests SHALL NOT be sampled in DONE, so a client holding its request through finished is not served twice; a new request is sampled in the IDLE cycle after DONE.
REQ-026 Latency: write with waitrequest=0 -> finished 2 cycles after the IDLE sample cycle; read -> finished 1 cycle after the readdatavalid cycle.
REQ-027 avm_readdatavalid outside WAIT_RD/REQ SHALL be ignored.
REQ-028 client_readdata SHALL change only on a read completion or timeout; writes leave it unchanged.
REQ-029 client_err SHALL stay 1 until reset.

Reset
REQ-030 On i_rst=0 at a clock edge: state=IDLE, counter=0, client_readdata=0, client_finished=0, client_err=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0.
REQ-031 Reset mid-operation SHALL abort with no client_finished; late controller responses SHALL be dropped per REQ-027.

Structure
REQ-032 State enum, ADDR_W/DATA_W defaults, TIMEOUT_CYC and TIMEOUT_DATA (32'hDEADBEEF) SHALL live in shared package sdram_pkg.
REQ-033 Single module; no sub-module.

Verification
REQ-034 write addr=23'h000010, data=32'h12345678, waitrequest=0 -> avm_write one cycle with those values; finished 2 cycles after sample; readdata unchanged.
REQ-035 read addr=23'h000010, waitrequest high 3 cycles, readdatavalid 2 cycles after accept with 32'hCAFEF00D -> address stable during stall; finished next cycle; readdata=32'hCAFEF00D.
REQ-036 client holds client_read for 5 cycles past finished -> exactly two reads issued, second starts in the IDLE cycle after DONE.
REQ-037 read with no readdatavalid -> finished after 256 WAIT_RD cycles; readdata=32'hDEADBEEF; err=1 and stays 1.
REQ-038 read+write both high -> only avm_read issued; err=1.
REQ-039 i_rst=0 while in WAIT_RD, then readdatavalid -> all outputs 0, no finished, state IDLE.

Source files
------------

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM client port responder.
//   - DEF_ADDR_W / DEF_DATA_W : default word address and data widths
//   - DEF_TIMEOUT_CYC         : default number of cycles waited for read data
//   - TIMEOUT_DATA            : value returned to the client on a read timeout
//   - state_t                 : responder FSM states (also exported for debug)
package sdram_pkg;

  localparam int DEF_ADDR_W      = 23;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 256;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/sdram_port_responder.sv
// sdram_port_responder: turns a simple held-request client interface into
// single Avalon-MM style commands towards an SDRAM controller.
//
// Ports
//   i_clk, i_rst        : clock, synchronous active-low reset
//   client_read/write   : request, held until client_finished
//   client_addr         : word address, client_writedata: write data
//   client_readdata     : read result, valid with client_finished and held
//   client_finished     : one-cycle completion pulse
//   client_err          : sticky error (read timeout or read+write together)
//   avm_*               : controller command side (address, read, write,
//                         writedata, byteenable, waitrequest, readdata,
//                         readdatavalid)
//   dbg_state           : current FSM state, for observation only
//
// Handshake: a command is held on avm_read/avm_write with stable address and
// data for every cycle avm_waitrequest=1; it is accepted in the first cycle
// the command is high and avm_waitrequest=0. Read data is taken from the
// first avm_readdatavalid=1 cycle at or after acceptance; avm_readdatavalid
// in any other state is ignored.
module sdram_port_responder
  import sdram_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              client_read,
  input  logic              client_write,
  input  logic [ADDR_W-1:0] client_addr,
  input  logic [DATA_W-1:0] client_writedata,
  output logic [DATA_W-1:0] client_readdata,
  output logic              client_finished,
  output logic              client_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output state_t            dbg_state
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              finished_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      finished_q <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      finished_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (client_read || client_write) begin
            // Read wins when both are raised; the conflict is flagged.
            addr_q  <= client_addr;
            wdata_q <= client_writedata;
            rd_q    <= client_read;
            wr_q    <= !client_read;
            if (client_read && client_write) err_q <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!avm_waitrequest) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            if (!rd_q) begin
              finished_q <= 1'b1;
              state_q    <= ST_DONE;
            end else if (avm_readdatavalid) begin
              // Controller returned data in the accept cycle itself.
              rdata_q    <= avm_readdata;
              finished_q <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              cnt_q   <= '0;
              state_q <= ST_WAIT_RD;
            end
          end
        end
        ST_WAIT_RD: begin
          if (avm_readdatavalid) begin
            rdata_q    <= avm_readdata;
            finished_q <= 1'b1;
            state_q    <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q    <= DATA_W'(TIMEOUT_DATA);
            err_q      <= 1'b1;
            finished_q <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Requests are not looked at here, so a client still holding its
          // request while seeing finished is not served a second time.
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign client_readdata = rdata_q;
  assign client_finished = finished_q;
  assign client_err      = err_q;
  assign avm_address     = addr_q;
  assign avm_read        = rd_q;
  assign avm_write       = wr_q;
  assign avm_writedata   = wdata_q;
  assign avm_byteenable  = 4'hF;
  assign dbg_state       = state_q;

endmodule
